// File: rtl/ac_compressor_ctrl.sv
// Compressor/fan sequencer: setpoint hysteresis with minimum on/off times,
// fan run-on after compressor stop and a saturating start counter.
module ac_compressor_ctrl #(
    parameter int ON_TH    = 20,
    parameter int OFF_TH   = 2,
    parameter int MIN_ON   = 120,
    parameter int MIN_OFF  = 180,
    parameter int FAN_POST = 30,
    parameter int TIMER_W  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        tick_i,
    input  logic [4:0]  temp_i,
    input  logic [4:0]  setpoint_i,
    output logic        compressor_o,
    output logic        fan_o,
    output logic [2:0]  state_o,
    output logic [15:0] starts_o
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_LOCKOUT = 3'd1,
        S_READY   = 3'd2,
        S_COOL    = 3'd3,
        S_RUNON   = 3'd4
    } state_t;

    localparam logic [4:0]         L_ON_TH    = 5'(ON_TH);
    localparam logic [4:0]         L_OFF_TH   = 5'(OFF_TH);
    localparam logic [TIMER_W-1:0] L_MIN_ON   = TIMER_W'(MIN_ON);
    localparam logic [TIMER_W-1:0] L_MIN_OFF  = TIMER_W'(MIN_OFF);
    localparam logic [TIMER_W-1:0] L_FAN_POST = TIMER_W'(FAN_POST);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [4:0]           r_diff;
    logic [15:0]          r_starts;
    logic [4:0]           w_diff;
    logic                 w_load;
    logic [TIMER_W-1:0]   w_load_val;
    logic                 w_start_inc;
    logic                 w_timer_zero;

    // Difference clamps at zero when the room is colder than the setpoint.
    assign w_diff       = (temp_i > setpoint_i) ? (temp_i - setpoint_i) : 5'd0;
    assign w_timer_zero = (r_timer == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_start_inc = 1'b0;
        case (r_state)
            S_OFF: begin
                if (start_i) begin
                    w_state_nxt = S_LOCKOUT;
                    w_load      = 1'b1;
                    w_load_val  = L_MIN_OFF;
                end
            end
            S_LOCKOUT: begin
                if (!start_i)          w_state_nxt = S_OFF;
                else if (w_timer_zero) w_state_nxt = S_READY;
            end
            S_READY: begin
                if (!start_i) begin
                    w_state_nxt = S_OFF;
                end else if (r_diff > L_ON_TH) begin
                    w_state_nxt = S_COOL;
                    w_load      = 1'b1;
                    w_load_val  = L_MIN_ON;
                    w_start_inc = 1'b1;
                end
            end
            S_COOL: begin
                // A stop request cuts the minimum on-time short.
                if (!start_i || (w_timer_zero && (r_diff <= L_OFF_TH))) begin
                    w_state_nxt = S_RUNON;
                    w_load      = 1'b1;
                    w_load_val  = L_FAN_POST;
                end
            end
            S_RUNON: begin
                if (w_timer_zero) begin
                    if (start_i) begin
                        w_state_nxt = S_LOCKOUT;
                        w_load      = 1'b1;
                        w_load_val  = L_MIN_OFF;
                    end else begin
                        w_state_nxt = S_OFF;
                    end
                end
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_OFF;
            r_timer <= '0;
            r_diff  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_diff  <= w_diff;
            if (w_load)
                r_timer <= w_load_val;
            else if (tick_i && !w_timer_zero)
                r_timer <= r_timer - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_starts <= '0;
        else if (w_start_inc && (r_starts != 16'hFFFF))
            r_starts <= r_starts + 16'd1;
    end

    assign compressor_o = (r_state == S_COOL);
    assign fan_o        = (r_state == S_COOL) || (r_state == S_RUNON);
    assign state_o      = r_state;
    assign starts_o     = r_starts;

endmodule
